eb_lane_serializer: RTL and testbench
=====================================

// Module: eb_lane_serializer
// PURPOSE
//  Splits a wide multi-lane vector word into one lane per cycle over a valid/ready stream.
//  Sits directly upstream of eb_two_slot; narrow output feeds its valid_in/ready_out/data_in.
//  Registers the wide word once, then walks a lane index. No bubbles between back-to-back words.
// PARAMETERS
//  DATA_WIDTH  16  width of one lane / output element
//  LANES       4   lanes per input word (>=2); CNT_W = $clog2(LANES+1) derived localparam
//  LSB_FIRST   1   1: lane 0 (data_in[DATA_WIDTH-1:0]) emitted first; 0: lane LANES-1 first
// PORTS
//  clk        in   1                   clock, rising edge
//  rst_n      in   1                   asynchronous reset, active low
//  valid_in   in   1                   upstream word valid
//  ready_out  out  1                   block accepts a word this cycle
//  data_in    in   LANES*DATA_WIDTH    wide word, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//  count_in   in   CNT_W               number of valid lanes in word (0..LANES)
//  valid_out  out  1                   element valid (to eb_two_slot valid_in)
//  ready_in   in   1                   downstream ready (from eb_two_slot ready_out)
//  data_out   out  DATA_WIDTH          current element
//  idx_out    out  CNT_W               position of current element within its word (0-based)
//  last_out   out  1                   only with SER_LAST_EN: final element of word
// BEHAVIOUR
//  - One clock, async active-low reset. Reset: state=IDLE, valid_out=0, idx_out=0, remaining=0,
//    last_out=0; ready_out=1 after reset. Lane holding register not reset.
//  - States: IDLE (no word held), SERIAL (word held, remaining>=1).
//  - Accept = valid_in & ready_out. ready_out = (state==IDLE) | (remaining==1 & ready_in).
//    The ready_in->ready_out path is combinational by design; downstream eb_two_slot ready is registered.
//  - On accept with eff_cnt>0: lanes captured, remaining<=eff_cnt, idx<=0, state<=SERIAL.
//    eff_cnt = min(count_in, LANES); count_in>LANES clamps to LANES.
//  - On accept with count_in==0: word dropped, no output. State is IDLE, or IDLE after the last beat.
//  - Latency: word accepted in cycle t -> first element valid_out=1 in t+1.
//    A word of k lanes occupies exactly k output handshakes.
//  - valid_out = (state==SERIAL). data_out = held lane selected by idx (reversed if LSB_FIRST=0).
//    data_out is driven from registers only.
//  - Element handshake = valid_out & ready_in: idx++, remaining--.
//    On remaining==1: IDLE, or new word loaded the same cycle (no bubble).
//  - Stall: while valid_out & ~ready_in, data_out/idx_out stay stable; valid_out never drops.
//  - Simultaneous last handshake + accept: new word's lane 0 is presented in the next cycle.
//  - valid_in while SERIAL and not on last beat: ready_out=0; upstream must hold its word.
//  - Reset mid-word: remaining lanes discarded; valid_out=0 asynchronously.
// CONFIGURATION
//  SER_LAST_EN defined: last_out port exists; last_out = valid_out & (remaining==1). Reset value 0.
//  SER_LAST_EN undefined: last_out port and its logic absent; all other behaviour identical.
// TESTING
//  Reset assert mid-word (rst_n=0 while remaining=3) -> valid_out=0 immediately.
//    After release: ready_out=1, idx_out=0.
//  LANES=4, LSB_FIRST=1, word 0xDDDD_CCCC_BBBB_AAAA, count_in=4, ready_in=1 ->
//    data_out AAAA,BBBB,CCCC,DDDD in 4 consecutive cycles; idx_out 0..3; last_out on DDDD.
//  Two back-to-back words (count_in 2 then 3), ready_in=1 ->
//    5 consecutive valid_out cycles with no gap; ready_out=1 only on beats 2 and 5.
//  count_in=4, ready_in toggles 1,0,0,1,1,0,1 -> data_out stable during stalls.
//    Exactly 4 handshakes in order; nothing lost or duplicated.
//  count_in=0 accepted in IDLE -> no valid_out. count_in=7 -> clamped to 4 elements.
//  LSB_FIRST=0, word 0xDDDD_CCCC_BBBB_AAAA, count_in=2 -> output DDDD then CCCC.
//    idx_out 0 then 1.

Source files
------------

// File: rtl/eb_lane_serializer.sv
// Wide-word to single-lane serializer with a valid/ready handshake on both sides.
// Optional last_out marker is enabled by defining SER_LAST_EN.
module eb_lane_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int LSB_FIRST  = 1,
    localparam int CNT_W     = $clog2(LANES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in,
    input  logic [CNT_W-1:0]              count_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [CNT_W-1:0]              idx_out
`ifdef SER_LAST_EN
    ,
    output logic                          last_out
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      eff_cnt;
    logic [CNT_W-1:0]      sel_lane;
    logic [DATA_WIDTH-1:0] lane_q [LANES];
    logic                  accept;
    logic                  elem_hs;
    logic                  load;

    always_comb begin
        eff_cnt = count_in;
        if (count_in > CNT_W'(LANES)) eff_cnt = CNT_W'(LANES);
    end

    // ready_in reaches ready_out combinationally so a new word loads on the last beat.
    assign ready_out = (state_q == IDLE) | ((rem_q == CNT_W'(1)) & ready_in);
    assign valid_out = (state_q == SERIAL);
    assign accept    = valid_in & ready_out;
    assign elem_hs   = valid_out & ready_in;
    assign load      = accept & (eff_cnt != '0);
    assign idx_out   = idx_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        if (elem_hs) begin
            rem_d = rem_q - CNT_W'(1);
            idx_d = idx_q + CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end
        // A zero-count word is consumed here without ever reaching SERIAL.
        if (load) begin
            state_d = SERIAL;
            rem_d   = eff_cnt;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        sel_lane = idx_q;
        if (LSB_FIRST == 0) sel_lane = CNT_W'(LANES - 1) - idx_q;
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel_lane == CNT_W'(i)) data_out = lane_q[i];
        end
    end

`ifdef SER_LAST_EN
    assign last_out = valid_out & (rem_q == CNT_W'(1));
`endif

endmodule

// File: tb/tb_eb_lane_serializer.sv
// Self-checking bench for eb_lane_serializer: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-based model of the emitted element stream.
module tb_eb_lane_serializer;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int CW = 3;
    localparam int EW = DW + DW + CW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_in;
    logic [LN*DW-1:0] data_in;
    logic [CW-1:0] count_in;

    logic          ready1, ready0, valid1, valid0;
    logic [DW-1:0] data1, data0;
    logic [CW-1:0] idx1, idx0;
    logic          last1, last0;

    int checks = 0;
    int errors = 0;

    // Expected element stream: {lsb-first data, msb-first data, idx, last}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    always #5 clk = ~clk;

`ifndef SER_LAST_EN
    assign last1 = 1'b0;
    assign last0 = 1'b0;
`endif

    eb_lane_serializer #(.DATA_WIDTH(DW), .LANES(LN), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready1),
        .data_in(data_in), .count_in(count_in), .valid_out(valid1),
        .ready_in(ready_in), .data_out(data1), .idx_out(idx1)
`ifdef SER_LAST_EN
        , .last_out(last1)
`endif
    );

    eb_lane_serializer #(.DATA_WIDTH(DW), .LANES(LN), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready0),
        .data_in(data_in), .count_in(count_in), .valid_out(valid0),
        .ready_in(ready_in), .data_out(data0), .idx_out(idx0)
`ifdef SER_LAST_EN
        , .last_out(last0)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model and per-cycle compare
    initial begin : monitor
        logic [EW-1:0] e;
        logic          exp_ready, do_pop, do_push;
        logic [LN*DW-1:0] w;
        int            k;
        forever begin
            @(negedge clk);
            do_pop  = 1'b0;
            do_push = 1'b0;
            k       = 0;
            w       = data_in;
            if (!rst_n) begin
                exp_q.delete();
                chk("rst_valid_lsb", 64'(valid1), 64'(0));
                chk("rst_valid_msb", 64'(valid0), 64'(0));
            end else begin
                exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ready_in);
                chk("valid_lsb", 64'(valid1), 64'(exp_q.size() > 0));
                chk("valid_msb", 64'(valid0), 64'(exp_q.size() > 0));
                chk("ready_lsb", 64'(ready1), 64'(exp_ready));
                chk("ready_msb", 64'(ready0), 64'(exp_ready));
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("data_lsb", 64'(data1), 64'(e[EW-1 -: DW]));
                    chk("data_msb", 64'(data0), 64'(e[EW-DW-1 -: DW]));
                    chk("idx_lsb", 64'(idx1), 64'(e[CW:1]));
                    chk("idx_msb", 64'(idx0), 64'(e[CW:1]));
`ifdef SER_LAST_EN
                    chk("last_lsb", 64'(last1), 64'(e[0]));
                    chk("last_msb", 64'(last0), 64'(e[0]));
`endif
                    if (ready_in) begin
                        do_pop = 1'b1;
                        obs_q.push_back({data1, data0, idx1, last1});
                    end
                end
                if (valid_in && exp_ready) begin
                    do_push = 1'b1;
                    k = (count_in > 3'(LN)) ? LN : int'(count_in);
                end
            end
            @(posedge clk);
            if (rst_n) begin
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    for (int j = 0; j < k; j++) begin
                        exp_q.push_back({w[j*DW +: DW], w[(LN-1-j)*DW +: DW], 3'(j), (j == k-1)});
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] w, input logic [CW-1:0] c);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        valid_in = 1'b1;
        data_in  = w;
        count_in = c;
        while (!done && n < 50) begin
            @(negedge clk);
            done = ready1;
            @(posedge clk);
            #1;
            n++;
        end
        valid_in = 1'b0;
        if (!done) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int   n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        while (busy && n < 20) begin
            @(negedge clk);
            busy = valid1;
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        logic [63:0] w;
        logic [DW-1:0] lit [LN];
        logic [6:0]  pat;
        logic        acc;
        w   = 64'hDDDD_CCCC_BBBB_AAAA;
        lit = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        pat = 7'b1001101;   // read LSB first: 1,0,1,1,0,0,1 reversed -> cycles use pat[6-i]
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        count_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready1), 64'(1));
        chk("reset_idx", 64'(idx1), 64'(0));
        chk("reset_valid", 64'(valid1), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_in = 1'b1;

        // Full word, lane 0 first
        send_word(w, 3'd4);
        for (int i = 0; i < LN; i++) begin
            @(negedge clk);
            chk("a_data_lsb", 64'(data1), 64'(lit[i]));
            chk("a_data_msb", 64'(data0), 64'(lit[LN-1-i]));
            chk("a_idx", 64'(idx1), 64'(i));
`ifdef SER_LAST_EN
            chk("a_last", 64'(last1), 64'(i == LN-1));
`endif
        end
        @(negedge clk);
        chk("a_idle_after", 64'(valid1), 64'(0));
        drain();

        // Back-to-back words of 2 then 3 lanes
        valid_in = 1'b1;
        data_in  = 64'h0004_0003_0002_0001;
        count_in = 3'd2;
        @(negedge clk);
        chk("b_ready_idle", 64'(ready1), 64'(1));
        @(posedge clk);
        #1;
        data_in  = 64'h0014_0013_0012_0011;
        count_in = 3'd3;
        for (int b = 1; b <= 5; b++) begin
            @(negedge clk);
            chk("b_valid", 64'(valid1), 64'(1));
            chk("b_ready", 64'(ready1), 64'(b == 2 || b == 5));
            @(posedge clk);
            #1;
            if (b == 2) valid_in = 1'b0;
        end
        drain();

        // Stall pattern 1,0,0,1,1,0,1
        obs_q.delete();
        send_word(w, 3'd4);
        for (int i = 0; i < 7; i++) begin
            ready_in = pat[6-i];
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk("c_idle", 64'(valid1), 64'(0));
        chk("c_count", 64'(obs_q.size()), 64'(4));
        for (int i = 0; i < obs_q.size() && i < LN; i++) begin
            chk("c_order", 64'(obs_q[i][EW-1 -: DW]), 64'(lit[i]));
        end
        drain();

        // Zero-count word dropped, oversized count clamped
        obs_q.delete();
        send_word(w, 3'd0);
        repeat (3) begin
            @(negedge clk);
            chk("d_zero_novalid", 64'(valid1), 64'(0));
        end
        @(posedge clk);
        #1;
        send_word(w, 3'd7);
        repeat (6) @(posedge clk);
        #1;
        chk("d_clamp_count", 64'(obs_q.size()), 64'(4));
        if (obs_q.size() == 4) chk("d_clamp_lastidx", 64'(obs_q[3][CW:1]), 64'(3));
        drain();

        // Two-lane word: msb-first instance emits DDDD then CCCC
        obs_q.delete();
        send_word(w, 3'd2);
        repeat (4) @(posedge clk);
        #1;
        chk("e_count", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() == 2) begin
            chk("e_msb0", 64'(obs_q[0][EW-DW-1 -: DW]), 64'(16'hDDDD));
            chk("e_msb1", 64'(obs_q[1][EW-DW-1 -: DW]), 64'(16'hCCCC));
            chk("e_idx0", 64'(obs_q[0][CW:1]), 64'(0));
            chk("e_idx1", 64'(obs_q[1][CW:1]), 64'(1));
            chk("e_lsb1", 64'(obs_q[1][EW-1 -: DW]), 64'(16'hBBBB));
        end
        drain();

        // Reset while three lanes remain
        send_word(w, 3'd4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("r_valid_async", 64'(valid1), 64'(0));
        chk("r_valid_async_msb", 64'(valid0), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("r_ready_after", 64'(ready1), 64'(1));
        chk("r_idx_after", 64'(idx1), 64'(0));
        @(posedge clk);
        #1;

        // Randomized traffic; upstream holds its word until accepted
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            acc = valid_in & ready1;
            @(posedge clk);
            #1;
            if (!valid_in || acc) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = {$urandom, $urandom};
                count_in = 3'($urandom_range(0, 7));
            end
            ready_in = ($urandom_range(0, 9) < 7);
        end
        drain();
        @(negedge clk);
        chk("end_model_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
